// File: rtl/stim_pkg.sv
// Shared types and constants for the x23 stimulus serializer.
package stim_pkg;

  // Main FSM states; StDone lasts exactly one clock.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2,
    StDone  = 2'd3
  } stim_state_e;

  localparam int unsigned StimWidthDefault = 32;

  // Length-field width for the default frame width.
  localparam int unsigned LEN_W = $clog2(StimWidthDefault + 1);

  localparam logic IdleLevelDefault = 1'b0;

  // Width of a length field able to hold 0..width inclusive.
  function automatic int unsigned len_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/stim_bit_timer.sv
// Bit-period divider: ticks on the last clock of every BIT_DIV-clock bit period.
module stim_bit_timer #(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned     CntW    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BIT_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == CntLast);

  // Next count: clear wins, otherwise wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Divider state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/x23_stimulus_serializer.sv
// Serial transmitter driving the x23 line: loads a word by handshake, shifts the active
// field out MSB-first with BIT_DIV clocks per bit, optional gap and optional repeat.
module x23_stimulus_serializer
  import stim_pkg::*;
#(
  parameter int unsigned  WIDTH      = StimWidthDefault,
  parameter int unsigned  BIT_DIV    = 1,
  parameter int unsigned  GAP_CYCLES = 4,
  parameter logic         IDLE_LEVEL = IdleLevelDefault,
  localparam int unsigned LenW       = len_width(WIDTH)
) (
  input  logic             my_clk,
  input  logic             global_reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LenW-1:0]  load_len,
  output logic             load_ready,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             x23_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned     GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;
  localparam logic [LenW-1:0] LenMax  = LenW'(WIDTH);

  stim_state_e      state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] frame_q;
  logic [WIDTH-1:0] load_aligned;
  logic [WIDTH-1:0] shift_next;
  logic [LenW-1:0]  len_q;
  logic [LenW-1:0]  left_q;
  logic [LenW-1:0]  len_clamped;
  logic [GapW-1:0]  gap_q;
  logic [15:0]      cnt_q;
  logic             rep_q;
  logic             x23_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             last_bit;
  logic             timer_en;
  logic             timer_clr;
  logic             bit_tick;

  assign load_ready = ready_q;
  assign x23_out    = x23_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_cnt  = cnt_q;

  // Clamp the length and left-align the active field so the next bit is always the MSB.
  always_comb begin
    len_clamped  = (load_len > LenMax) ? LenMax : load_len;
    load_aligned = load_data << (LenMax - len_clamped);
    shift_next   = shift_q << 1;
    last_bit     = (left_q == LenW'(1));
    timer_en     = (state_q == StShift);
    // Holding the divider clear outside SHIFT makes every frame start on a fresh bit period.
    timer_clr    = ~timer_en;
  end

  stim_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .clk_i  (my_clk),
    .rst_ni (global_reset),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .tick_o (bit_tick)
  );

  // Main FSM with registered serial output, status flags and frame counter.
  always_ff @(posedge my_clk or negedge global_reset) begin
    if (!global_reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      frame_q <= '0;
      len_q   <= '0;
      left_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      x23_q   <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort is meaningless here, so a handshake in the same cycle still completes.
          if (load_valid) begin
            if (len_clamped == '0) begin
              // Empty frame: acknowledge with done but do not count it.
              done_q <= 1'b1;
            end else begin
              shift_q <= load_aligned;
              frame_q <= load_aligned;
              len_q   <= len_clamped;
              left_q  <= len_clamped;
              rep_q   <= repeat_en;
              x23_q   <= load_aligned[WIDTH-1];
              state_q <= StShift;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end

        StShift: begin
          if (abort) begin
            state_q <= StIdle;
            x23_q   <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (bit_tick) begin
            if (last_bit) begin
              x23_q <= IDLE_LEVEL;
              if (GAP_CYCLES > 0) begin
                state_q <= StGap;
                gap_q   <= GapLast;
              end else begin
                state_q <= StDone;
                done_q  <= 1'b1;
                cnt_q   <= cnt_q + 16'd1;
                busy_q  <= rep_q;
              end
            end else begin
              shift_q <= shift_next;
              x23_q   <= shift_next[WIDTH-1];
              left_q  <= left_q - LenW'(1);
            end
          end
        end

        StGap: begin
          if (abort) begin
            state_q <= StIdle;
            x23_q   <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (gap_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            cnt_q   <= cnt_q + 16'd1;
            busy_q  <= rep_q;
          end else begin
            gap_q <= gap_q - GapW'(1);
          end
        end

        StDone: begin
          // The live repeat_en can end a stream; it cannot start one.
          if (!abort && rep_q && repeat_en) begin
            shift_q <= frame_q;
            left_q  <= len_q;
            x23_q   <= frame_q[WIDTH-1];
            state_q <= StShift;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            x23_q   <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          x23_q   <= IDLE_LEVEL;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x23_stimulus_serializer.sv
// Bench for x23_stimulus_serializer: two instances (8-bit fast, 32-bit divided with gap),
// a vector table, randomized frames against a stream model, and hand-written corner cases.
module tb_x23_stimulus_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, BIT_DIV=1, GAP_CYCLES=0
  logic        a_valid, a_rep, a_abort, a_ready, a_x, a_busy, a_done;
  logic [7:0]  a_data;
  logic [3:0]  a_len;
  logic [15:0] a_cnt;
  // Instance B: WIDTH=32, BIT_DIV=3, GAP_CYCLES=4
  logic        b_valid, b_rep, b_abort, b_ready, b_x, b_busy, b_done;
  logic [31:0] b_data;
  logic [5:0]  b_len;
  logic [15:0] b_cnt;

  x23_stimulus_serializer #(
    .WIDTH      (8),
    .BIT_DIV    (1),
    .GAP_CYCLES (0),
    .IDLE_LEVEL (1'b0)
  ) u_dut_a (
    .my_clk       (clk),
    .global_reset (rst_n),
    .load_valid   (a_valid),
    .load_data    (a_data),
    .load_len     (a_len),
    .load_ready   (a_ready),
    .repeat_en    (a_rep),
    .abort        (a_abort),
    .x23_out      (a_x),
    .busy         (a_busy),
    .done         (a_done),
    .frame_cnt    (a_cnt)
  );

  x23_stimulus_serializer #(
    .WIDTH      (32),
    .BIT_DIV    (3),
    .GAP_CYCLES (4),
    .IDLE_LEVEL (1'b0)
  ) u_dut_b (
    .my_clk       (clk),
    .global_reset (rst_n),
    .load_valid   (b_valid),
    .load_data    (b_data),
    .load_len     (b_len),
    .load_ready   (b_ready),
    .repeat_en    (b_rep),
    .abort        (b_abort),
    .x23_out      (b_x),
    .busy         (b_busy),
    .done         (b_done),
    .frame_cnt    (b_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt [2];

  typedef struct {
    bit          s;
    logic [31:0] data;
    int          len;
    bit          hs_abort;
    int          exp_lat;
    logic [31:0] exp_bits;
  } vec_t;

  vec_t tbl [8];

  function automatic int w_of(input bit s);
    return s ? 32 : 8;
  endfunction

  function automatic int d_of(input bit s);
    return s ? 3 : 1;
  endfunction

  function automatic int g_of(input bit s);
    return s ? 4 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit s, input logic v, input logic [31:0] d, input int len,
                       input logic r, input logic ab);
    if (s) begin
      b_valid = v; b_data = d; b_len = 6'(len); b_rep = r; b_abort = ab;
    end else begin
      a_valid = v; a_data = d[7:0]; a_len = 4'(len); a_rep = r; a_abort = ab;
    end
  endtask

  task automatic sample(input bit s, output logic x, output logic bz, output logic rd,
                        output logic dn, output logic [15:0] c);
    if (s) begin
      x = b_x; bz = b_busy; rd = b_ready; dn = b_done; c = b_cnt;
    end else begin
      x = a_x; bz = a_busy; rd = a_ready; dn = a_done; c = a_cnt;
    end
  endtask

  // Called just after a negedge. Sends one frame and checks every cycle against the
  // expected serial stream; returns the observed done latency and the sampled bits.
  task automatic run_frame(input bit s, input logic [31:0] data, input int len,
                           input bit spam, input bit hs_abort,
                           output int lat, output logic [31:0] bits);
    int    w     = w_of(s);
    int    dv    = d_of(s);
    int    g     = g_of(s);
    int    l     = (len > w) ? w : len;
    int    nbits = l * dv;
    int    total = (l == 0) ? 1 : nbits + g + 1;
    string nm    = s ? "B" : "A";
    logic  x, bz, rd, dn, ex, eb, er, ed;
    logic [15:0] c;
    lat  = -1;
    bits = '0;
    drive(s, 1'b1, data, len, 1'b0, hs_abort);
    @(negedge clk);
    drive(s, 1'b0, data, len, 1'b0, 1'b0);
    if (l > 0) exp_cnt[s]++;
    for (int n = 1; n <= total + 1; n++) begin
      if (n > 1) @(negedge clk);
      sample(s, x, bz, rd, dn, c);
      if (l == 0) begin
        ex = 1'b0; eb = 1'b0; er = 1'b1; ed = (n == 1);
      end else if (n <= nbits) begin
        ex = data[l - 1 - (n - 1) / dv]; eb = 1'b1; er = 1'b0; ed = 1'b0;
      end else if (n < total) begin
        ex = 1'b0; eb = 1'b1; er = 1'b0; ed = 1'b0;
      end else if (n == total) begin
        ex = 1'b0; eb = 1'b0; er = 1'b0; ed = 1'b1;
      end else begin
        ex = 1'b0; eb = 1'b0; er = 1'b1; ed = 1'b0;
      end
      chk($sformatf("%s x23 c%0d", nm, n), {31'b0, x}, {31'b0, ex});
      chk($sformatf("%s busy c%0d", nm, n), {31'b0, bz}, {31'b0, eb});
      chk($sformatf("%s ready c%0d", nm, n), {31'b0, rd}, {31'b0, er});
      chk($sformatf("%s done c%0d", nm, n), {31'b0, dn}, {31'b0, ed});
      if (dn === 1'b1 && lat < 0) lat = n;
      if (l > 0 && n <= nbits && ((n - 1) % dv) == 0) bits = {bits[30:0], x};
      if (spam && l > 0) begin
        if (n == 1) drive(s, 1'b1, ~data, w, 1'b0, 1'b0);
        if (n == total) drive(s, 1'b0, data, len, 1'b0, 1'b0);
      end
    end
    chk($sformatf("%s frame_cnt", nm), {16'b0, c}, 32'(exp_cnt[s] & 16'hFFFF));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1);
  end

  initial begin
    logic        x, bz, rd, dn;
    logic [15:0] c;
    logic [31:0] bits;
    int          lat, dones, sel, len;

    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0);

    // Reset state on both instances
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s[0], x, bz, rd, dn, c);
      chk($sformatf("rst x23 %0d", s), {31'b0, x}, 32'd0);
      chk($sformatf("rst busy %0d", s), {31'b0, bz}, 32'd0);
      chk($sformatf("rst ready %0d", s), {31'b0, rd}, 32'd1);
      chk($sformatf("rst done %0d", s), {31'b0, dn}, 32'd0);
      chk($sformatf("rst cnt %0d", s), {16'b0, c}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: {instance, data, len, abort-at-handshake, latency, bits sent}
    tbl[0] = '{1'b0, 32'h0000_00A5, 8,  1'b0, 9,   32'h0000_00A5};
    tbl[1] = '{1'b1, 32'h0000_0006, 3,  1'b0, 14,  32'h0000_0006};
    tbl[2] = '{1'b0, 32'h0000_00FF, 0,  1'b0, 1,   32'h0000_0000};
    tbl[3] = '{1'b1, 32'hDEAD_BEEF, 40, 1'b0, 101, 32'hDEAD_BEEF};
    tbl[4] = '{1'b0, 32'h0000_005A, 12, 1'b0, 9,   32'h0000_005A};
    tbl[5] = '{1'b0, 32'h0000_00F3, 3,  1'b0, 4,   32'h0000_0003};
    tbl[6] = '{1'b1, 32'h0000_0001, 1,  1'b0, 8,   32'h0000_0001};
    tbl[7] = '{1'b0, 32'h0000_0081, 8,  1'b1, 9,   32'h0000_0081};
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].s, tbl[i].data, tbl[i].len, i[0], tbl[i].hs_abort, lat, bits);
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d bits", i), bits, tbl[i].exp_bits);
    end

    // Randomized frames against the stream model
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 1);
      len = $urandom_range(0, w_of(sel[0]) + 3);
      run_frame(sel[0], $urandom, len, 1'($urandom_range(0, 1)), 1'b0, lat, bits);
    end

    // Repeat on A: 2'b10 every 3 clocks, repeat_en dropped during the 3rd done
    drive(1'b0, 1'b1, 32'h2, 2, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h2, 2, 1'b1, 1'b0);
    dones = 0;
    for (int n = 1; n <= 14; n++) begin
      if (n > 1) @(negedge clk);
      sample(1'b0, x, bz, rd, dn, c);
      if (n <= 9) begin
        chk($sformatf("rep x23 c%0d", n), {31'b0, x}, {31'b0, (n % 3) == 1});
        chk($sformatf("rep done c%0d", n), {31'b0, dn}, {31'b0, (n % 3) == 0});
        if ((n % 3) != 0 || n < 9) chk($sformatf("rep busy c%0d", n), {31'b0, bz}, 32'd1);
      end else begin
        chk($sformatf("rep idle done c%0d", n), {31'b0, dn}, 32'd0);
        chk($sformatf("rep idle ready c%0d", n), {31'b0, rd}, 32'd1);
        chk($sformatf("rep idle busy c%0d", n), {31'b0, bz}, 32'd0);
      end
      if (dn === 1'b1) dones++;
      if (n == 9) drive(1'b0, 1'b0, 32'h2, 2, 1'b0, 1'b0);
    end
    exp_cnt[0] += 3;
    chk("rep done count", 32'(dones), 32'd3);
    chk("rep frame_cnt", {16'b0, c}, 32'(exp_cnt[0] & 16'hFFFF));

    // Abort on B during the 4th shift cycle
    drive(1'b1, 1'b1, 32'hFF, 8, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hFF, 8, 1'b0, 1'b0);
    for (int n = 2; n <= 4; n++) @(negedge clk);
    sample(1'b1, x, bz, rd, dn, c);
    chk("abort pre busy", {31'b0, bz}, 32'd1);
    chk("abort pre x23", {31'b0, x}, 32'd1);
    drive(1'b1, 1'b0, 32'hFF, 8, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hFF, 8, 1'b0, 1'b0);
    sample(1'b1, x, bz, rd, dn, c);
    chk("abort x23", {31'b0, x}, 32'd0);
    chk("abort busy", {31'b0, bz}, 32'd0);
    chk("abort ready", {31'b0, rd}, 32'd1);
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (b_done === 1'b1) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    chk("abort frame_cnt", {16'b0, b_cnt}, 32'(exp_cnt[1] & 16'hFFFF));

    // Abort on A coinciding with the final bit: abort wins over completion
    drive(1'b0, 1'b1, 32'h3, 2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h3, 2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h3, 2, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h3, 2, 1'b0, 1'b0);
    sample(1'b0, x, bz, rd, dn, c);
    chk("lastabort done", {31'b0, dn}, 32'd0);
    chk("lastabort ready", {31'b0, rd}, 32'd1);
    chk("lastabort x23", {31'b0, x}, 32'd0);
    @(negedge clk);
    sample(1'b0, x, bz, rd, dn, c);
    chk("lastabort done2", {31'b0, dn}, 32'd0);
    chk("lastabort frame_cnt", {16'b0, c}, 32'(exp_cnt[0] & 16'hFFFF));

    // Reset mid-frame on B, then a full frame afterwards
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 20, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 20, 1'b0, 1'b0);
    for (int n = 2; n <= 5; n++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sample(1'b1, x, bz, rd, dn, c);
    chk("midrst x23", {31'b0, x}, 32'd0);
    chk("midrst busy", {31'b0, bz}, 32'd0);
    chk("midrst ready", {31'b0, rd}, 32'd1);
    chk("midrst done", {31'b0, dn}, 32'd0);
    chk("midrst cnt B", {16'b0, c}, 32'd0);
    chk("midrst cnt A", {16'b0, a_cnt}, 32'd0);
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1'b1, 32'h6, 3, 1'b0, 1'b0, lat, bits);
    chk("postrst latency", 32'(lat), 32'd14);
    chk("postrst bits", bits, 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
